// File: rtl/mem_arbiter_n.sv
// N-port memory arbiter: fixed-priority grant, wait states, burst hold with a beat cap, request-withdraw abort.
// Define ARB_ROUND_ROBIN_EN to rotate the search start below the last completed owner.
module mem_arbiter_n #(
  parameter int NPORTS      = 4,
  parameter int ID_W        = 2,
  parameter int WAIT_CYCLES = 2,
  parameter int MAX_BURST   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NPORTS-1:0] read_request,
  input  logic [NPORTS-1:0] write_request,
  input  logic              skip_wait,
  output logic [NPORTS-1:0] grant,
  output logic [ID_W-1:0]   grant_id,
  output logic              memory_sel,
  output logic              rwbar,
  output logic              ready,
  output logic              busy,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, READY = 2'd2} state_t;

  localparam int IDX_W  = $clog2(NPORTS);
  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam logic [3:0]        WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST - 1);

  state_t            state;
  logic [NPORTS-1:0] req;
  logic [IDX_W-1:0]  win;
  logic [IDX_W-1:0]  owner;
  logic [3:0]        wait_cnt;
  logic [BEAT_W-1:0] beat;
  logic              own_req;
  logic              burst_more;

  assign fsm_state  = state;
  assign req        = read_request | write_request;
  assign owner      = IDX_W'(grant_id);
  assign own_req    = req[owner];
  assign burst_more = own_req && (beat < BEAT_LAST);

`ifdef ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] last;
  int              idx;

  // Candidates are visited from (last-1) downward with wraparound; the final overwrite is the first candidate.
  always_comb begin
    win = '0;
    idx = 0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      idx = (int'(last) + 2 * NPORTS - 1 - k) % NPORTS;
      if (req[IDX_W'(idx)]) win = IDX_W'(idx);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last <= '0;
    end else if (state == READY && !burst_more) begin
      last <= grant_id;
    end
  end
`else
  always_comb begin
    win = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (req[IDX_W'(i)]) win = IDX_W'(i);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= '0;
      grant_id   <= '0;
      memory_sel <= 1'b0;
      rwbar      <= 1'b1;
      ready      <= 1'b0;
      busy       <= 1'b0;
      beat       <= '0;
      wait_cnt   <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state      <= ACCESS;
            grant      <= NPORTS'(1) << win;
            grant_id   <= ID_W'(win);
            memory_sel <= 1'b1;
            rwbar      <= ~write_request[win];
            wait_cnt   <= WAIT_INIT;
            beat       <= '0;
            busy       <= 1'b1;
          end
        end
        ACCESS: begin
          if (!own_req) begin
            // Requester withdrew: drop the bus without completing the beat.
            state      <= IDLE;
            grant      <= '0;
            grant_id   <= '0;
            memory_sel <= 1'b0;
            rwbar      <= 1'b1;
            busy       <= 1'b0;
          end else if (skip_wait || wait_cnt == 4'd0) begin
            state <= READY;
            ready <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        READY: begin
          if (burst_more) begin
            state    <= ACCESS;
            beat     <= beat + 1'b1;
            wait_cnt <= WAIT_INIT;
            rwbar    <= ~write_request[owner];
          end else begin
            state      <= IDLE;
            grant      <= '0;
            grant_id   <= '0;
            memory_sel <= 1'b0;
            rwbar      <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Directed bench for mem_arbiter_n (default parameters); expectations switch on ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter_n;

  localparam int NPORTS = 4;
  localparam int ID_W   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NPORTS-1:0] read_request = '0;
  logic [NPORTS-1:0] write_request = '0;
  logic              skip_wait = 1'b0;
  logic [NPORTS-1:0] grant;
  logic [ID_W-1:0]   grant_id;
  logic              memory_sel;
  logic              rwbar;
  logic              ready;
  logic              busy;
  logic [1:0]        fsm_state;

  int n_vec  = 0;
  int n_miss = 0;
  int pulses;
  logic [ID_W-1:0] exp_q[$];
  logic [ID_W-1:0] exp_id;

  mem_arbiter_n #(.NPORTS(4), .ID_W(2), .WAIT_CYCLES(2), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .read_request(read_request), .write_request(write_request), .skip_wait(skip_wait),
    .grant(grant), .grant_id(grant_id), .memory_sel(memory_sel), .rwbar(rwbar),
    .ready(ready), .busy(busy), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    read_request  = '0;
    write_request = '0;
    skip_wait     = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    while (grant === '0 && n < 20) begin
      tick();
      n++;
    end
    check(tag, {31'd0, |grant}, 32'd1);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    // reset state
    do_reset();
    check("rst_grant", grant, 0);
    check("rst_id", grant_id, 0);
    check("rst_sel", memory_sel, 0);
    check("rst_rwbar", rwbar, 1);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    check("rst_state", fsm_state, 0);

    // single read on port 1, two wait states
    read_request[1] = 1'b1;
    tick();
    check("t1_grant", grant, 4'b0010);
    check("t1_id", grant_id, 1);
    check("t1_rwbar", rwbar, 1);
    check("t1_sel", memory_sel, 1);
    check("t1_busy", busy, 1);
    check("t1_rdy_c1", ready, 0);
    tick();
    check("t1_rdy_c2", ready, 0);
    tick();
    check("t1_rdy_c3", ready, 0);
    tick();
    check("t1_rdy_c4", ready, 1);
    read_request[1] = 1'b0;
    tick();
    check("t1_rdy_c5", ready, 0);
    check("t1_state_c5", fsm_state, 0);
    check("t1_grant_c5", grant, 0);
    check("t1_busy_c5", busy, 0);

    // port 2 read against port 0 write: index decides, then one idle cycle
    do_reset();
    read_request[2]  = 1'b1;
    write_request[0] = 1'b1;
    tick();
    check("t2_grant_p2", grant, 4'b0100);
    check("t2_rwbar_p2", rwbar, 1);
    tick();
    tick();
    tick();
    check("t2_rdy_p2", ready, 1);
    read_request[2] = 1'b0;
    tick();
    check("t2_gap_grant", grant, 0);
    check("t2_gap_state", fsm_state, 0);
    tick();
    check("t2_grant_p0", grant, 4'b0001);
    check("t2_id_p0", grant_id, 0);
    check("t2_rwbar_p0", rwbar, 0);
    tick();
    tick();
    tick();
    check("t2_rdy_p0", ready, 1);
    write_request[0] = 1'b0;
    tick();

    // burst capped at 4 beats, write wins on a port asserting both, skip_wait
    do_reset();
    skip_wait        = 1'b1;
    write_request[2] = 1'b1;
    read_request[2]  = 1'b1;
    read_request[1]  = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      pulses += int'(ready);
      check("t3_rwbar", rwbar, 0);
      check("t3_grant", grant, 4'b0100);
      check("t3_ready", ready, (c % 2 == 0) ? 1 : 0);
    end
    check("t3_pulses", pulses, 4);
    tick();
    check("t3_cap_grant", grant, 0);
    check("t3_cap_state", fsm_state, 0);
    tick();
`ifdef ARB_ROUND_ROBIN_EN
    check("t3_regrant", grant, 4'b0010);
`else
    check("t3_regrant", grant, 4'b0100);
`endif

    // abort: port 1 withdraws in its second wait cycle
    do_reset();
    read_request[1] = 1'b1;
    tick();
    check("t4_state_c1", fsm_state, 1);
    tick();
    check("t4_state_c2", fsm_state, 1);
    check("t4_rdy_c2", ready, 0);
    read_request[1] = 1'b0;
    tick();
    check("t4_grant", grant, 0);
    check("t4_sel", memory_sel, 0);
    check("t4_state", fsm_state, 0);
    check("t4_rdy_c3", ready, 0);
    tick();
    check("t4_rdy_c4", ready, 0);

    // reset during READY of the second beat, then restart from beat 0
    do_reset();
    skip_wait        = 1'b1;
    write_request[3] = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check("t5_rdy_b1", ready, 1);
    check("t5_rwbar_b1", rwbar, 0);
    rst = 1'b0;
    tick();
    check("t5_grant", grant, 0);
    check("t5_ready", ready, 0);
    check("t5_rwbar", rwbar, 1);
    check("t5_busy", busy, 0);
    check("t5_sel", memory_sel, 0);
    check("t5_state", fsm_state, 0);
    rst = 1'b1;
    pulses = 0;
    for (int c = 6; c <= 13; c++) begin
      tick();
      pulses += int'(ready);
      check("t5_hold", grant, 4'b1000);
    end
    check("t5_pulses", pulses, 4);
    tick();
    check("t5_end_grant", grant, 0);

    // scoreboard: grant order with ports 0..2 requesting single beats
    do_reset();
    skip_wait = 1'b1;
    exp_q.delete();
    for (int r = 0; r < 2; r++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_q.push_back(2'd2);
      exp_q.push_back(2'd1);
      exp_q.push_back(2'd0);
`else
      exp_q.push_back(2'd2);
      exp_q.push_back(2'd2);
      exp_q.push_back(2'd2);
`endif
    end
    read_request = 4'b0111;
    while (exp_q.size() > 0) begin
      wait_grant("t6_grant_timeout");
      exp_id = exp_q.pop_front();
      check("t6_id", grant_id, exp_id);
      check("t6_onehot", grant, 4'b0001 << exp_id);
      wait_ready("t6_ready_timeout");
      read_request[grant_id] = 1'b0;
      tick();
      read_request = 4'b0111;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_n.md
Name: mem_arbiter_n

Overview:
- Parametrised N-port memory arbiter; successor to the fixed 4-port priority arbiter between the caches/DMA and the shared SRAM bus.
- Adds configurable port count, programmable wait states, multi-beat burst hold with a starvation cap, request-withdraw abort, and an optional round-robin mode.
- Sits between requesters (dcache, icache, dma_controller, future masters) and the memory: it drives the chip select and read/write strobe and returns a per-beat ready.

Parameters:
- NPORTS, 4, number of requester ports (2..16).
- ID_W, 2, width of grant_id; must be at least clog2(NPORTS).
- WAIT_CYCLES, 2, extra memory wait states per beat (0..15).
- MAX_BURST, 4, maximum consecutive beats per grant before forced re-arbitration (1..16).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- read_request  in  NPORTS  per-port read request; level, held until ready.
- write_request  in  NPORTS  per-port write request; level, held until ready.
- skip_wait  in  1  from addr_decode; when high, the current beat completes with no wait states.
- grant  out  NPORTS  one-hot grant; all zero when idle.
- grant_id  out  ID_W  binary index of the granted port; 0 when idle.
- memory_sel  out  1  memory chip select.
- rwbar  out  1  1 = read, 0 = write.
- ready  out  1  one-cycle pulse; the current beat has completed.
- busy  out  1  high in ACCESS and READY.

Behaviour:
- All outputs are registered.
- Reset (rst=0 sampled at an edge): state=IDLE, grant=0, grant_id=0, memory_sel=0, rwbar=1, ready=0, busy=0, beat counter=0, wait counter=0, last-grant pointer=0. Reset mid-operation aborts the beat immediately; no ready is issued.
- A port's request is req[i] = read_request[i] | write_request[i].
- If a port asserts both read and write, write wins (rwbar=0).
- FSM states: IDLE, ACCESS, READY.
- IDLE:
  - If any req is high, select a winner (see arbitration).
  - At the same edge: set grant to one-hot, set grant_id, memory_sel=1, rwbar=~write_request[w], wait counter=WAIT_CYCLES, beat=0; go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - If req[w]=0: abort. Clear grant and memory_sel, go to IDLE, no ready.
  - Else if skip_wait=1 or wait counter=0: go to READY and set ready=1.
  - Else decrement the wait counter.
- READY (ready high for exactly one cycle):
  - If req[w]=1 and beat < MAX_BURST-1: beat++, reload the wait counter, re-evaluate rwbar from port w, go to ACCESS with grant held.
  - Otherwise: record last=w, clear grant, grant_id, memory_sel and busy, go to IDLE.
  - This forces at least one IDLE cycle between different owners.
- Latency: with request sampled at edge 0, grant is visible after edge 0, and ready is high in cycle WAIT_CYCLES+2 (cycle 2 with skip_wait=1).
- Burst timing: each further beat adds WAIT_CYCLES+2 cycles (2 with skip_wait).
- Requests arriving while busy are ignored until IDLE; they are not queued.
- Requesters must hold their address and data while granted.
- Arbitration (default, fixed priority): the highest index with req high wins. For the existing mapping this gives dcache(2) > icache(1) > dma(0).
- Simultaneous read and write from different ports resolve by index only; direction does not affect priority.
- grant and ready are never asserted for more than one port.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Undefined: fixed priority as above; the last-grant pointer is unused.
- Defined: the search starts at (last-1) mod NPORTS and proceeds downward with wraparound.
  - After reset last=0, so the first search starts at NPORTS-1, identical to fixed priority.
  - The pointer updates only when a grant ends in READY; aborts do not update it.
  - MAX_BURST combined with rotation guarantees any requester is served within NPORTS grants.

Test Plan:
- Single read, port 1, WAIT_CYCLES=2, skip_wait=0 -> grant=4'b0010 and grant_id=1 after edge 0; rwbar=1; memory_sel=1; ready high in cycle 4 only; back to IDLE in cycle 5.
- Ports 0 and 2 request together, fixed priority -> port 2 granted first. Port 0 granted only after one IDLE cycle following port 2's final ready.
- Port 2 holds its write request for 6 beats, MAX_BURST=4, skip_wait=1 -> 4 ready pulses 2 cycles apart, rwbar=0 throughout; grant drops and IDLE follows. Port 2 is then re-granted (fixed priority), or port 1 is granted if requesting (round-robin).
- Port 1 drops its request during ACCESS, 2nd wait cycle -> no ready; grant=0 and memory_sel=0 on the next cycle; state=IDLE.
- rst=0 asserted during READY of a burst -> next cycle grant=0, ready=0, rwbar=1, busy=0; a request after release restarts from beat 0.
- ARB_ROUND_ROBIN_EN defined, ports 0, 1, 2 all requesting continuously with single beats -> grant order 2, 1, 0, 2, 1, 0.
